// File: rtl/pipelined_parallel_adder.sv
// Pipelined WIDTH-bit adder: a + b + c_in split over STAGES registered carry-chain slices.
// Optional signed overflow output is built when PADD_OVERFLOW_EN is defined.
`timescale 1ns/1ps
module pipelined_parallel_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef PADD_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int SLICE = WIDTH / STAGES;

  logic en;

  // Stall is global: every stage holds while a result waits downstream.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  for (genvar j = 0; j < STAGES; j++) begin : g_stage
    localparam int LO = j * SLICE;
    localparam int HI = LO + SLICE - 1;

    logic [SLICE-1:0] op_a, op_b;
    logic             cy_in, v_in;
    logic [SLICE:0]   add;
    logic [HI:0]      s_next, s;
    logic             cy, v;

    // Stage j holds the finished low sum bits [HI:0]; upper operand bits ride in g_skew.
    if (j == 0) begin : g_src
      assign op_a   = a[HI:LO];
      assign op_b   = b[HI:LO];
      assign cy_in  = c_in;
      assign v_in   = in_valid;
      assign s_next = add[SLICE-1:0];
    end else begin : g_src
      assign op_a   = g_stage[j-1].g_skew.ra[HI:LO];
      assign op_b   = g_stage[j-1].g_skew.rb[HI:LO];
      assign cy_in  = g_stage[j-1].cy;
      assign v_in   = g_stage[j-1].v;
      assign s_next = {add[SLICE-1:0], g_stage[j-1].s};
    end

    assign add = {1'b0, op_a} + {1'b0, op_b} + {{SLICE{1'b0}}, cy_in};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s  <= '0;
        cy <= 1'b0;
        v  <= 1'b0;
      end else if (en) begin
        s  <= s_next;
        cy <= add[SLICE];
        v  <= v_in;
      end
    end

    if (j < STAGES - 1) begin : g_skew
      logic [WIDTH-1:HI+1] ra_next, rb_next, ra, rb;

      if (j == 0) begin : g_in
        assign ra_next = a[WIDTH-1:HI+1];
        assign rb_next = b[WIDTH-1:HI+1];
      end else begin : g_in
        assign ra_next = g_stage[j-1].g_skew.ra[WIDTH-1:HI+1];
        assign rb_next = g_stage[j-1].g_skew.rb[WIDTH-1:HI+1];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ra <= '0;
          rb <= '0;
        end else if (en) begin
          ra <= ra_next;
          rb <= rb_next;
        end
      end
    end

`ifdef PADD_OVERFLOW_EN
    if (j == STAGES - 1) begin : g_ovf
      logic ovf;
      // Carry into the MSB is a^b^sum at that bit; XOR with carry-out gives signed overflow.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          ovf <= 1'b0;
        else if (en)
          ovf <= op_a[SLICE-1] ^ op_b[SLICE-1] ^ add[SLICE-1] ^ add[SLICE];
      end
    end
`endif
  end

  assign sum       = g_stage[STAGES-1].s;
  assign c_out     = g_stage[STAGES-1].cy;
  assign out_valid = g_stage[STAGES-1].v;
`ifdef PADD_OVERFLOW_EN
  assign overflow  = g_stage[STAGES-1].g_ovf.ovf;
`endif

endmodule

// File: tb/tb_pipelined_parallel_adder.sv
// Bench for pipelined_parallel_adder: directed checks on a 16/4 instance plus random
// sweeps on 16/4, 16/1 and 8/8 instances against a queue-based arithmetic model.
`timescale 1ns/1ps
module tb_pipelined_parallel_adder;

`ifdef PADD_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Directed instance
  logic        rst_n, in_valid, in_ready, c_in, out_valid, out_ready, c_out, ovf;
  logic [15:0] a, b, sum;

  pipelined_parallel_adder #(.WIDTH(16), .STAGES(4)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .c_out    (c_out)
`ifdef PADD_OVERFLOW_EN
    ,
    .overflow (ovf)
`endif
  );
`ifndef PADD_OVERFLOW_EN
  assign ovf = 1'b0;
`endif

  task automatic single_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                           input logic tc, input logic [15:0] es, input logic ec,
                           input logic eo);
    int lat;
    @(negedge clk);
    check({tag, "_in_ready"}, in_ready, 1);
    a = ta; b = tb; c_in = tc; in_valid = 1'b1; out_ready = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    check({tag, "_latency"}, lat, 4);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, c_out, ec);
    check({tag, "_ovf"}, ovf, OVF_EN ? eo : 1'b0);
    @(negedge clk);
    check({tag, "_one_cycle"}, out_valid, 0);
  endtask

  task automatic backpressure();
    logic [15:0] oa[3], ob[3], es[3];
    logic        ec[3];
    int          idx, stall;
    bit          stall_done;
    oa = '{16'h0001, 16'h00FF, 16'h8000};
    ob = '{16'h0001, 16'h0001, 16'h8000};
    es = '{16'h0002, 16'h0100, 16'h0000};
    ec = '{1'b0, 1'b0, 1'b1};
    idx = 0; stall = 0; stall_done = 0;
    @(negedge clk);
    a = oa[0]; b = ob[0]; c_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    for (int t = 1; t < 30 && idx < 3; t++) begin
      @(negedge clk);
      if (t < 3) begin
        a = oa[t]; b = ob[t];
      end else begin
        in_valid = 1'b0;
      end
      if (stall > 0) begin
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_sum", sum, es[0]);
        check("bp_hold_cout", c_out, ec[0]);
        check("bp_stall_in_ready", in_ready, 0);
        stall--;
        if (stall == 0) begin
          out_ready = 1'b1;
          idx = 1;
        end
      end else if (out_valid) begin
        check("bp_sum", sum, es[idx]);
        check("bp_cout", c_out, ec[idx]);
        if (idx == 0 && !stall_done) begin
          out_ready = 1'b0; stall = 2; stall_done = 1;
        end else begin
          idx++;
        end
      end
    end
    check("bp_result_count", idx, 3);
    @(negedge clk);
    check("bp_no_extra", out_valid, 0);
  endtask

  task automatic mid_reset();
    int stale;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; a = 16'd1; b = 16'd2; c_in = 1'b0;
    for (int t = 1; t < 4; t++) begin
      @(negedge clk);
      if (t < 3) a = a + 16'd1;
      else in_valid = 1'b0;
    end
    @(negedge clk);
    check("rst_pre_valid", out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_valid", out_valid, 0);
    check("rst_async_sum", sum, 0);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("rst_stale_results", stale, 0);
  endtask

  // Random sweep instances
  logic sw_rst_n;
  initial begin
    sw_rst_n = 1'b0;
    repeat (3) @(negedge clk);
    sw_rst_n = 1'b1;
  end

  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int W = (g == 2) ? 8 : 16;
    localparam int S = (g == 0) ? 4 : (g == 1) ? 1 : 8;

    logic         iv, ir, ci, ov, orr, co, of;
    logic [W-1:0] ra, rb, rs;
    logic         done = 1'b0;

    pipelined_parallel_adder #(.WIDTH(W), .STAGES(S)) u_sw (
      .clk      (clk),
      .rst_n    (sw_rst_n),
      .in_valid (iv),
      .in_ready (ir),
      .a        (ra),
      .b        (rb),
      .c_in     (ci),
      .out_valid(ov),
      .out_ready(orr),
      .sum      (rs),
      .c_out    (co)
`ifdef PADD_OVERFLOW_EN
      ,
      .overflow (of)
`endif
    );
`ifndef PADD_OVERFLOW_EN
    assign of = 1'b0;
`endif

    initial begin : drive
      logic [W+1:0] exp_q[$];
      int unsigned  tag_q[$];
      int unsigned  en_cnt, accepted;
      logic [W+1:0] prev_out, full;
      logic [W:0]   tot;
      logic         stalled, exp_v, acc;
      en_cnt = 0; accepted = 0; stalled = 1'b0; prev_out = '0;
      iv = 1'b0; ci = 1'b0; ra = '0; rb = '0; orr = 1'b0;
      wait (sw_rst_n);
      for (int cyc = 0; cyc < 30000 && !(accepted >= 1000 && exp_q.size() == 0); cyc++) begin
        @(negedge clk);
        if (stalled) check($sformatf("sw%0d_hold", g), {of, co, rs}, prev_out);
        iv  = (accepted < 1000) && ($urandom_range(3) != 0);
        orr = ($urandom_range(9) < 7);
        ra  = W'($urandom); rb = W'($urandom); ci = 1'($urandom);
        #1;
        // An op is at the output once S enabled edges have passed since its acceptance.
        exp_v = (exp_q.size() != 0) && (en_cnt - tag_q[0] == S);
        check($sformatf("sw%0d_valid", g), ov, exp_v);
        check($sformatf("sw%0d_in_ready", g), ir, !exp_v || orr);
        if (exp_v && orr) begin
          check($sformatf("sw%0d_result", g), {of, co, rs}, exp_q.pop_front());
          void'(tag_q.pop_front());
        end
        acc = iv && (!exp_v || orr);
        if (acc) begin
          tot  = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, ci};
          full = {OVF_EN && (ra[W-1] == rb[W-1]) && (tot[W-1] != ra[W-1]), tot};
          exp_q.push_back(full);
          tag_q.push_back(en_cnt);
          accepted++;
        end
        if (!exp_v || orr) en_cnt++;
        stalled  = exp_v && !orr;
        prev_out = {of, co, rs};
      end
      iv = 1'b0; orr = 1'b1;
      check($sformatf("sw%0d_drained", g), exp_q.size(), 0);
      check($sformatf("sw%0d_accepted", g), accepted, 1000);
      done = 1'b1;
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; c_in = 1'b0;
    repeat (3) begin
      @(negedge clk);
      in_valid = 1'($urandom); out_ready = 1'($urandom);
      a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom);
    end
    #1;
    check("reset_sum", sum, 16'h0000);
    check("reset_cout", c_out, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;

    single_op("basic",  16'h0005, 16'h000D, 1'b0, 16'h0012, 1'b0, 1'b0);
    single_op("ripple", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    single_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    single_op("ovf_neg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    single_op("ovf_none", 16'h0003, 16'hFFFF, 1'b0, 16'h0002, 1'b1, 1'b0);
    backpressure();
    mid_reset();

    for (int i = 0; i < 40000; i++) begin
      if (g_sweep[0].done && g_sweep[1].done && g_sweep[2].done) break;
      @(negedge clk);
    end
    check("sweeps_done", {g_sweep[0].done, g_sweep[1].done, g_sweep[2].done}, 3'b111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/pipelined_parallel_adder.md
# pipelined_parallel_adder

Parametrised, pipelined successor to the 4-bit parallel adder. It adds two WIDTH-bit operands plus carry-in across STAGES registered carry-chain slices. Throughput is one addition per clock, with a valid/ready handshake on both sides. It is the datapath adder for the wider arithmetic blocks, where a single-cycle ripple chain no longer meets timing.

## Interface
Parameters:
- WIDTH, 16, operand and sum width in bits; must be ≥ 1 and divisible by STAGES
- STAGES, 4, number of pipeline slices; each slice adds SLICE = WIDTH/STAGES bits; must be ≥ 1

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst_n  input  1  reset, asynchronous and active-low
- in_valid  input  1  a/b/c_in hold a valid operation
- in_ready  output  1  block can accept an operation this cycle
- a  input  WIDTH  operand A (unsigned; two's complement for overflow)
- b  input  WIDTH  operand B
- c_in  input  1  carry into bit 0
- out_valid  output  1  sum/c_out hold a valid result
- out_ready  input  1  downstream accepts the result this cycle
- sum  output  WIDTH  a + b + c_in, modulo 2^WIDTH
- c_out  output  1  carry out of bit WIDTH-1
- overflow  output  1  signed overflow; present only with PADD_OVERFLOW_EN

## Operation
- Stage k (0..STAGES-1) adds slice k of a and b (bits k·SLICE .. k·SLICE+SLICE-1) plus the registered carry from stage k-1. Stage 0 uses c_in.
- Operand slices for stage k travel through k skew registers so they meet their carry.
- Result slices are de-skewed: slice k waits STAGES-1-k extra registers, so all WIDTH sum bits emerge together.
- Each stage has a valid bit; the valid bits form a STAGES-deep shift register.
- Global advance: en = !out_valid || out_ready. When en = 0, every stage register holds.
- in_ready = en. A transfer occurs when in_valid && in_ready; otherwise a bubble (valid = 0) enters stage 0.
- Bubbles are not collapsed; stall is global.
- Results leave in acceptance order; none are dropped or duplicated.
- STAGES = 1 degenerates to a single registered full-width adder.
- No state machine beyond the valid shift register.

## Timing
- Reset (rst_n low, asynchronous): all valid bits 0; sum = 0, c_out = 0, overflow = 0, out_valid = 0. in_ready reads 1 because it follows out_valid = 0.
- Deassertion of rst_n is synchronised externally; the first transfer may occur on the first rising edge with rst_n high.
- Latency: an operation accepted at edge N appears with out_valid = 1 after edge N+STAGES-1, i.e. it is visible in the cycle following edge N+STAGES-1. This assumes no stalls.
- Each stall cycle (out_valid && !out_ready) adds exactly one cycle of latency to every in-flight operation.
- While stalled, sum, c_out, overflow and out_valid are stable.
- Throughput: one result per cycle while out_ready = 1.
- Simultaneous input acceptance and output drain in the same cycle is legal and required.
- Reset mid-operation discards all in-flight results; none appear after reset release.
- Carry propagation: a carry generated in slice 0 must reach c_out of the same operation (e.g. all-ones + c_in).

## Configuration
- PADD_OVERFLOW_EN defined: the overflow port exists and is valid with out_valid.
  - overflow = carry into bit WIDTH-1 XOR c_out, for the same operation.
  - The carry into bit WIDTH-1 is captured in the last stage.
- PADD_OVERFLOW_EN undefined: the overflow port and its logic are absent; other behaviour is unchanged.

## Test plan
- Reset: hold rst_n = 0 with random inputs → sum = 0x0000, c_out = 0, out_valid = 0, in_ready = 1. Assert rst_n low mid-stream with 3 operations in flight → out_valid = 0 immediately, and no stale result appears after release.
- Basic (WIDTH = 16, STAGES = 4): a = 0x0005, b = 0x000D, c_in = 0, out_ready = 1 → sum = 0x0012, c_out = 0, out_valid high exactly 4 cycles after acceptance for one cycle.
- Full ripple: a = 0xFFFF, b = 0x0000, c_in = 1 → sum = 0x0000, c_out = 1.
- Backpressure: issue 0x0001+0x0001, 0x00FF+0x0001, 0x8000+0x8000 back-to-back, and drop out_ready for 2 cycles when the first result appears. Required:
  - outputs held and in_ready = 0 during the stall;
  - results 0x0002/0, 0x0100/0, 0x0000/1 in order, none lost.
- Overflow (PADD_OVERFLOW_EN): 0x7FFF+0x0001 → sum 0x8000, c_out 0, overflow 1. 0x8000+0x8000 → sum 0x0000, c_out 1, overflow 1. 0x0003+0xFFFF → overflow 0.
- Parameter sweep: STAGES = 1 (latency 1) and WIDTH = 8/STAGES = 8 (latency 8), each with 1000 random operations at random out_ready → every result equals a+b+c_in.
